// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file slice.
// Optional write-through bypass is enabled with REGFILE_BYPASS_EN (see regfile_mp).
package regfile_pkg;

    typedef enum logic {RF_CLEAR, RF_READY} rf_state_e;

    // Address width for an array of n entries; never less than one bit.
    function automatic int unsigned rf_aw(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: walks clr_idx over every entry after reset or on request,
// then holds READY until the next clear request.
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int unsigned N_REGS = 32,
    localparam int unsigned AW    = rf_aw(N_REGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic          ready,
    output logic          clr_we,
    output logic [AW-1:0] clr_idx
);

    rf_state_e     state;
    rf_state_e     state_nxt;
    logic [AW-1:0] idx_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= RF_CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_nxt;
            clr_idx <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = clr_idx;
        case (state)
            RF_CLEAR: begin
                if (clr_idx == AW'(N_REGS - 1)) begin
                    state_nxt = RF_READY;
                end else begin
                    idx_nxt = clr_idx + 1'b1;
                end
            end
            RF_READY: begin
                if (clr_req) begin
                    state_nxt = RF_CLEAR;
                    idx_nxt   = '0;
                end
            end
            default: state_nxt = RF_CLEAR;
        endcase
    end

    always_comb begin
        ready  = (state == RF_READY);
        clr_we = (state == RF_CLEAR);
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NR async reads, NW sync writes, built-in clear.
// Define REGFILE_BYPASS_EN to forward same-cycle accepted writes to the read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned N_REGS  = 32,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NR      = 2,
    parameter int unsigned NW      = 1,
    parameter int unsigned ZERO_X0 = 1,
    localparam int unsigned AW     = rf_aw(N_REGS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NW-1:0]      wen,
    input  logic [NW*AW-1:0]   waddr,
    input  logic [NW*XLEN-1:0] wdata,
    input  logic [NR*AW-1:0]   raddr,
    output logic [NR*XLEN-1:0] rdata,
    input  logic               clr_req,
    output logic               ready,
    output logic               wr_drop
);

    logic [XLEN-1:0] regs [N_REGS];
    logic            clr_we;
    logic [AW-1:0]   clr_idx;
    logic [NW-1:0]   acc;
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rv;

    regfile_clr_seq #(.N_REGS(N_REGS)) u_clr_seq (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_req (clr_req),
        .ready   (ready),
        .clr_we  (clr_we),
        .clr_idx (clr_idx)
    );

    // A write is accepted only in READY outside a clear-request cycle; x0 writes vanish silently.
    always_comb begin
        acc = '0;
        for (int unsigned i = 0; i < NW; i++) begin
            acc[i] = wen[i] && ready && !clr_req &&
                     !((ZERO_X0 != 0) && (waddr[i*AW +: AW] == '0));
        end
    end

    // Ascending port order lets the highest-index port win an address collision.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            regs[clr_idx] <= '0;
        end else begin
            for (int unsigned i = 0; i < NW; i++) begin
                if (acc[i]) begin
                    regs[waddr[i*AW +: AW]] <= wdata[i*XLEN +: XLEN];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_drop <= 1'b0;
        end else if ((|wen) && (!ready || clr_req)) begin
            wr_drop <= 1'b1;
        end
    end

    always_comb begin
        rdata = '0;
        ra    = '0;
        rv    = '0;
        for (int unsigned j = 0; j < NR; j++) begin
            ra = raddr[j*AW +: AW];
            rv = regs[ra];
`ifdef REGFILE_BYPASS_EN
            for (int unsigned i = 0; i < NW; i++) begin
                if (acc[i] && (waddr[i*AW +: AW] == ra)) begin
                    rv = wdata[i*XLEN +: XLEN];
                end
            end
`endif
            if (!ready || ((ZERO_X0 != 0) && (ra == '0))) begin
                rv = '0;
            end
            rdata[j*XLEN +: XLEN] = rv;
        end
    end

endmodule
